// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between a producer and the UART transmitter
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with CTS# flow control, LSB-first, optional even parity
module uart_tx #(
   parameter int CLK_FREQ_HZ    = 12_000_000,
   parameter int BAUD_RATE_BPS  = 115_200,
   parameter int BAUD_COUNT     = CLK_FREQ_HZ / BAUD_RATE_BPS,
   parameter int UART_DATA_BITS = 8,
   parameter int PARITY_BITS    = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic     clk,
   input  logic     resetn,
   uart_tx_if.slave bus,
   input  logic     uart0_cts,
   output logic     uart0_txd,
   output logic     busy
);
   localparam int              CW        = $clog2(BAUD_COUNT);
   localparam logic [CW-1:0]   RELOAD    = CW'(BAUD_COUNT - 1);
   localparam logic [3:0]      LAST_DATA = 4'(UART_DATA_BITS - 1);
   localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, WAIT_CTS, START, DATA, PARITY, STOP} state_t;

   state_t                    state, next_state;
   logic [CW-1:0]             cnt, cnt_next;
   logic [3:0]                bit_idx, idx_next;
   logic [UART_DATA_BITS-1:0] shift, shift_next;
   logic                      par, par_next;
   logic                      txd_next;
   logic                      ready_q;
   logic                      cts_meta, cts_s;
   logic                      bit_end;

   assign bus.tx_ready = ready_q;
   assign bit_end      = (cnt == '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cts_meta <= 1'b1;
         cts_s    <= 1'b1;
      end else begin
         cts_meta <= uart0_cts;
         cts_s    <= cts_meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         par       <= 1'b0;
         uart0_txd <= 1'b1;
         busy      <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= cnt_next;
         bit_idx   <= idx_next;
         shift     <= shift_next;
         par       <= par_next;
         uart0_txd <= txd_next;
         busy      <= (next_state != IDLE);
         ready_q   <= (next_state == IDLE);
      end
   end

   always_comb begin
      next_state = state;
      idx_next   = bit_idx;
      shift_next = shift;
      par_next   = par;
      cnt_next   = cnt;
      txd_next   = 1'b1;

      case (state)
         IDLE: begin
            if (bus.tx_valid && ready_q) begin
               shift_next = bus.tx_data;
               par_next   = ^bus.tx_data;
               idx_next   = '0;
               next_state = cts_s ? WAIT_CTS : START;
            end
         end
         WAIT_CTS: begin
            if (!cts_s) next_state = START;
         end
         START: begin
            if (bit_end) next_state = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_next = shift >> 1;
               if (bit_idx == LAST_DATA) begin
                  idx_next   = '0;
                  next_state = (PARITY_BITS != 0) ? PARITY : STOP;
               end else begin
                  idx_next = bit_idx + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) next_state = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (bit_idx == LAST_STOP) begin
                  idx_next   = '0;
                  next_state = IDLE;
               end else begin
                  idx_next = bit_idx + 4'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase

      // Counter restarts on every bit boundary, including the jump into START.
      if (next_state == IDLE || next_state == WAIT_CTS)
         cnt_next = '0;
      else if (state == IDLE || state == WAIT_CTS || bit_end)
         cnt_next = RELOAD;
      else
         cnt_next = cnt - CW'(1);

      // txd is registered from the next state so the line is glitch-free.
      case (next_state)
         START:   txd_next = 1'b0;
         DATA:    txd_next = shift_next[0];
         PARITY:  txd_next = par_next;
         default: txd_next = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (12 clks per bit)
module tb_uart_tx;
   logic clk;
   logic resetn;
   logic cts0, ctsp;
   logic txd0, txdp;
   logic busy0, busyp;
   logic sel;
   logic s_txd, s_busy, s_ready;
   int   checks;
   int   errors;

   uart_tx_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_if #(.DATA_BITS(8)) busp ();

   uart_tx #(
      .CLK_FREQ_HZ(12_000_000), .BAUD_RATE_BPS(1_000_000),
      .UART_DATA_BITS(8), .PARITY_BITS(0), .STOP_BITS(1)
   ) u_dut (
      .clk(clk), .resetn(resetn), .bus(bus0),
      .uart0_cts(cts0), .uart0_txd(txd0), .busy(busy0)
   );

   uart_tx #(
      .CLK_FREQ_HZ(12_000_000), .BAUD_RATE_BPS(1_000_000),
      .UART_DATA_BITS(8), .PARITY_BITS(1), .STOP_BITS(2)
   ) u_dut_p (
      .clk(clk), .resetn(resetn), .bus(busp),
      .uart0_cts(ctsp), .uart0_txd(txdp), .busy(busyp)
   );

   assign s_txd   = sel ? txdp : txd0;
   assign s_busy  = sel ? busyp : busy0;
   assign s_ready = sel ? busp.tx_ready : bus0.tx_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic [7:0] d, input logic v);
      if (sel) begin
         busp.tx_data  = d;
         busp.tx_valid = v;
      end else begin
         bus0.tx_data  = d;
         bus0.tx_valid = v;
      end
   endtask

   // Leaves tx_valid high; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] d, input string name);
      bit done;
      done = 0;
      drive(d, 1'b1);
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (s_ready === 1'b1) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s accept: tx_ready never seen high within 300 clks", name);
      end
   endtask

   // Call #1 after the edge that put the start bit on the line.
   task automatic check_frame(input logic [15:0] expv, input int nbits, input string name);
      int   bad_txd;
      int   bad_ctl;
      logic last_bad;
      bad_ctl = 0;
      for (int b = 0; b < nbits; b++) begin
         bad_txd  = 0;
         last_bad = 1'bx;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s_txd !== expv[b]) begin
               bad_txd++;
               last_bad = s_txd;
            end
            if (s_busy !== 1'b1 || s_ready !== 1'b0) bad_ctl++;
         end
         checks++;
         if (bad_txd != 0) begin
            errors++;
            $display("FAIL %s bit %0d: txd=%b required %b in %0d of 12 clks", name, b, last_bad, expv[b], bad_txd);
         end
      end
      checks++;
      if (bad_ctl != 0) begin
         errors++;
         $display("FAIL %s ctl: busy/tx_ready wrong in %0d clks, required busy=1 tx_ready=0", name, bad_ctl);
      end
      @(negedge clk);
      checks++;
      if (s_txd !== 1'b1 || s_busy !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s end: txd=%b busy=%b tx_ready=%b required 1 0 1", name, s_txd, s_busy, s_ready);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cts0 = 1'b0;
      ctsp = 1'b0;
      sel = 1'b0;
      bus0.tx_data = '0; bus0.tx_valid = 1'b0;
      busp.tx_data = '0; busp.tx_valid = 1'b0;
      #12;
      checks++;
      if (txd0 !== 1'b1 || busy0 !== 1'b0 || bus0.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset: txd=%b busy=%b tx_ready=%b required 1 0 0", txd0, busy0, bus0.tx_ready);
      end
      checks++;
      if (txdp !== 1'b1 || busyp !== 1'b0 || busp.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_p: txd=%b busy=%b tx_ready=%b required 1 0 0", txdp, busyp, busp.tx_ready);
      end
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (bus0.tx_ready !== 1'b1 || busp.tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: tx_ready=%b/%b required 1/1", bus0.tx_ready, busp.tx_ready);
      end
   endtask

   task automatic test_basic();
      sel = 1'b0;
      send(8'hA5, "basic");
      drive(8'hA5, 1'b0);
      check_frame({1'b1, 8'hA5, 1'b0}, 10, "basic");
   endtask

   task automatic test_cts_hold();
      int bad;
      sel = 1'b0;
      cts0 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(8'h3C, "cts_hold");
      drive(8'h00, 1'b0);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (txd0 !== 1'b1 || busy0 !== 1'b1 || bus0.tx_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL cts_hold wait: %0d of 50 clks wrong, required txd=1 busy=1 tx_ready=0", bad);
      end
      @(posedge clk);
      #1;
      cts0 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (txd0 !== 1'b1) begin
         errors++;
         $display("FAIL cts_hold early: txd=%b after 2nd edge, required 1", txd0);
      end
      @(posedge clk);
      #1;
      check_frame({1'b1, 8'h3C, 1'b0}, 10, "cts_hold");
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      send(8'h00, "b2b_first");
      drive(8'hFF, 1'b1);
      check_frame({1'b1, 8'h00, 1'b0}, 10, "b2b_first");
      @(posedge clk);
      #1;
      drive(8'hFF, 1'b0);
      checks++;
      if (busy0 !== 1'b1 || txd0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: busy=%b txd=%b after single idle clk, required 1 0", busy0, txd0);
      end
      check_frame({1'b1, 8'hFF, 1'b0}, 10, "b2b_second");
   endtask

   task automatic test_parity();
      sel = 1'b1;
      send(8'h07, "parity");
      drive(8'h07, 1'b0);
      check_frame({2'b11, 1'b1, 8'h07, 1'b0}, 12, "parity");
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      int bad;
      sel = 1'b0;
      send(8'h55, "reset_mid");
      drive(8'h55, 1'b0);
      repeat (66) @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++;
      if (txd0 !== 1'b1 || busy0 !== 1'b0 || bus0.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: txd=%b busy=%b tx_ready=%b required 1 0 0", txd0, busy0, bus0.tx_ready);
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++;
      if (bus0.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ready_first: tx_ready=%b required 0", bus0.tx_ready);
      end
      @(negedge clk);
      checks++;
      if (bus0.tx_ready !== 1'b1 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ready_second: tx_ready=%b busy=%b required 1 0", bus0.tx_ready, busy0);
      end
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (txd0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_mid residue: %0d of 30 clks with txd!=1 or busy!=0", bad);
      end
   endtask

   task automatic test_cts_mid();
      int bad;
      sel = 1'b0;
      cts0 = 1'b0;
      send(8'h81, "cts_mid");
      drive(8'h42, 1'b1);
      fork
         check_frame({1'b1, 8'h81, 1'b0}, 10, "cts_mid");
         begin
            repeat (40) @(negedge clk);
            cts0 = 1'b1;
         end
      join
      @(posedge clk);
      #1;
      drive(8'h42, 1'b0);
      checks++;
      if (busy0 !== 1'b1 || bus0.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL cts_mid queued: busy=%b tx_ready=%b required 1 0", busy0, bus0.tx_ready);
      end
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (txd0 !== 1'b1 || busy0 !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL cts_mid hold: %0d of 20 clks wrong, required txd=1 busy=1", bad);
      end
      @(posedge clk);
      #1;
      cts0 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (txd0 !== 1'b1) begin
         errors++;
         $display("FAIL cts_mid early: txd=%b after 2nd edge, required 1", txd0);
      end
      @(posedge clk);
      #1;
      check_frame({1'b1, 8'h42, 1'b0}, 10, "cts_mid_next");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_cts_hold();
      test_back_to_back();
      test_parity();
      test_reset_mid();
      test_cts_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
